neuron_mac_accumulator: RTL

Per-neuron multiply-accumulate stage. It streams NUM_INPUTS signed activation/weight pairs over a valid/ready handshake and adds each full-precision product to a bias-preloaded accumulator. It emits one ACC_WIDTH-bit signed sum per neuron. The sum feeds overflow_underflow_rectifier directly, which saturates it to 16 bits; this block does no saturation.

---
 rtl/neuron_mac_if.sv | 25 ++
 rtl/neuron_mac_accumulator.sv | 91 +++++++++
 2 files changed

// File: rtl/neuron_mac_if.sv
// Handshake bundle between the neuron sequencer and the MAC accumulator:
// bias/start control, activation/weight stream and the per-neuron sum.
interface neuron_mac_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) ();
  logic                         start_in;
  logic signed [DATA_WIDTH-1:0] bias_in;
  logic                         data_valid_in;
  logic                         data_ready_out;
  logic signed [DATA_WIDTH-1:0] activation_in;
  logic signed [DATA_WIDTH-1:0] weight_in;
  logic                         sum_valid_out;
  logic signed [ACC_WIDTH-1:0]  sum_out;

  modport master (
    output start_in, bias_in, data_valid_in, activation_in, weight_in,
    input  data_ready_out, sum_valid_out, sum_out
  );

  modport slave (
    input  start_in, bias_in, data_valid_in, activation_in, weight_in,
    output data_ready_out, sum_valid_out, sum_out
  );
endinterface

// File: rtl/neuron_mac_accumulator.sv
// Per-neuron MAC: bias-preloaded accumulator fed by a registered product stage,
// emitting one wrapping ACC_WIDTH-bit sum per NUM_INPUTS accepted pairs.
module neuron_mac_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_INPUTS = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  neuron_mac_if.slave bus
);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int CNT_W  = $clog2(NUM_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, ACCUMULATE, DRAIN, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         beat_cnt;
  logic                     accept_p0;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;
  logic signed [ACC_WIDTH-1:0] acc_p2;

  function automatic logic signed [ACC_WIDTH-1:0] sext_bias(
    input logic signed [DATA_WIDTH-1:0] b);
    return ACC_WIDTH'(b);
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(
    input logic signed [PROD_W-1:0] p);
    return ACC_WIDTH'(p);
  endfunction

  // Ready depends on state only so the upstream never sees a combinational path.
  assign bus.data_ready_out = (state == ACCUMULATE);
  assign accept_p0          = bus.data_valid_in && bus.data_ready_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      beat_cnt          <= '0;
      prod_p1           <= '0;
      vld_p1            <= 1'b0;
      acc_p2            <= '0;
      bus.sum_out       <= '0;
      bus.sum_valid_out <= 1'b0;
    end else begin
      bus.sum_valid_out <= 1'b0;

      // p0 -> p1: register the full-precision product of the accepted pair
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        prod_p1  <= PROD_W'(bus.activation_in) * PROD_W'(bus.weight_in);
        beat_cnt <= beat_cnt + CNT_W'(1);
      end

      // p1 -> p2: fold the product into the accumulator (wraps, never saturates)
      if (vld_p1) begin
        acc_p2 <= acc_p2 + sext_prod(prod_p1);
      end

      // vld_p1 is always low in IDLE, so the bias preload never races an add.
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            acc_p2   <= sext_bias(bus.bias_in);
            beat_cnt <= '0;
            state    <= ACCUMULATE;
          end
        end
        ACCUMULATE: begin
          if (accept_p0 && (beat_cnt == LAST_BEAT)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= DONE;
        end
        DONE: begin
          bus.sum_out       <= acc_p2;
          bus.sum_valid_out <= 1'b1;
          state             <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
